// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared seven-segment pattern table and scan constants
package sevenseg_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] AN_BLANK   = 4'hF;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  typedef enum logic [1:0] {
    AN_NONE  = 2'd0,
    AN_ONE   = 2'd1,
    AN_MULTI = 2'd2
  } an_kind_e;

  function automatic logic [6:0] hex_to_sseg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

  function automatic an_kind_e classify_an(input logic [3:0] an);
    an_kind_e kind;
    case ($countones(~an))
      0:       kind = AN_NONE;
      1:       kind = AN_ONE;
      default: kind = AN_MULTI;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/sevenseg_to_hex.sv
// rtl/sevenseg_to_hex.sv - combinational segment-pattern to hex nibble decoder
module sevenseg_to_hex
  import sevenseg_pkg::*;
(
  input  logic [6:0] sseg,
  output logic [3:0] nibble,
  output logic       hit
);

  // Searches the shared encoder table so both directions can never disagree
  always_comb begin
    nibble = 4'h0;
    hit    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (sseg == hex_to_sseg(4'(i))) begin
        nibble = 4'(i);
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/time_mux_scan_decoder.sv
// rtl/time_mux_scan_decoder.sv - captures a scanned seven-segment display back into a 16-bit value
module time_mux_scan_decoder
  import sevenseg_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int STALE_CYCLES  = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [6:0]  sseg,
  output logic [15:0] value,
  output logic [3:0]  digit_valid,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        an_err,
  output logic        stale
);

  localparam int STALE_W = $clog2(STALE_CYCLES + 1);

  logic [3:0]         r_an;
  logic [6:0]         r_sseg;
  logic [3:0]         r_prev_an;
  logic [6:0]         r_prev_sseg;
  logic [7:0]         r_settle_cnt;
  logic               r_captured;
  logic [3:0]         r_seen;
  logic [STALE_W-1:0] r_stale_cnt;
  logic [15:0]        r_value;
  logic [3:0]         r_digit_valid;
  logic               r_frame_valid;
  logic               r_seg_err;
  logic               r_an_err;
  logic               r_stale;

  logic               w_changed;
  logic [7:0]         w_settle_next;
  logic               w_capture;
  an_kind_e           w_kind;
  logic [3:0]         w_slot_mask;
  logic [3:0]         w_nibble;
  logic               w_hit;
  logic               w_good;
  logic               w_bad_seg;
  logic               w_bad_an;
  logic [3:0]         w_seen_upd;
  logic               w_frame;
  logic [STALE_W-1:0] w_stale_next;
  logic               w_stale_hit;

  sevenseg_to_hex u_decode (
    .sseg   (r_sseg),
    .nibble (w_nibble),
    .hit    (w_hit)
  );

  // The dwell is judged on the sample against its predecessor, so capture lands SETTLE_CYCLES edges after sampling
  always_comb begin
    w_changed     = {r_an, r_sseg} != {r_prev_an, r_prev_sseg};
    w_settle_next = w_changed ? 8'd1
                  : (r_settle_cnt == 8'(SETTLE_CYCLES)) ? r_settle_cnt
                  : r_settle_cnt + 8'd1;
    w_capture     = !w_changed && !r_captured && (w_settle_next == 8'(SETTLE_CYCLES));
    w_kind        = classify_an(r_an);
    w_slot_mask   = ~r_an;
    w_good        = w_capture && (w_kind == AN_ONE) && w_hit;
    w_bad_seg     = w_capture && (w_kind == AN_ONE) && !w_hit;
    w_bad_an      = w_capture && (w_kind == AN_MULTI);
    w_seen_upd    = r_seen | w_slot_mask;
    w_frame       = w_good && (w_seen_upd == 4'hF);
    w_stale_next  = (r_stale_cnt == STALE_W'(STALE_CYCLES)) ? r_stale_cnt
                  : r_stale_cnt + STALE_W'(1);
    w_stale_hit   = (w_stale_next == STALE_W'(STALE_CYCLES));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_an          <= '0;
      r_sseg        <= '0;
      r_prev_an     <= '0;
      r_prev_sseg   <= '0;
      r_settle_cnt  <= '0;
      r_captured    <= 1'b0;
      r_seen        <= '0;
      r_stale_cnt   <= '0;
      r_value       <= '0;
      r_digit_valid <= '0;
      r_frame_valid <= 1'b0;
      r_seg_err     <= 1'b0;
      r_an_err      <= 1'b0;
      r_stale       <= 1'b0;
    end else begin
      r_an          <= an;
      r_sseg        <= sseg;
      r_prev_an     <= r_an;
      r_prev_sseg   <= r_sseg;
      r_settle_cnt  <= w_settle_next;
      r_captured    <= w_changed ? 1'b0 : (r_captured | w_capture);
      r_frame_valid <= w_frame;
      r_seg_err     <= w_bad_seg;
      r_an_err      <= w_bad_an;
      if (w_good) begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
          if (w_slot_mask[k]) r_value[k*4 +: 4] <= w_nibble;
        end
        r_digit_valid <= r_digit_valid | w_slot_mask;
        r_seen        <= w_frame ? 4'h0 : w_seen_upd;
        r_stale_cnt   <= '0;
        r_stale       <= 1'b0;
      end else begin
        r_stale_cnt <= w_stale_next;
        if (w_stale_hit) begin
          r_stale       <= 1'b1;
          r_digit_valid <= '0;
          r_seen        <= '0;
        end else if (w_bad_seg) begin
          r_digit_valid <= r_digit_valid & ~w_slot_mask;
          r_seen        <= r_seen & ~w_slot_mask;
        end
      end
    end
  end

  assign value       = r_value;
  assign digit_valid = r_digit_valid;
  assign frame_valid = r_frame_valid;
  assign seg_err     = r_seg_err;
  assign an_err      = r_an_err;
  assign stale       = r_stale;

endmodule

// File: tb/tb_time_mux_scan_decoder.sv
// tb/tb_time_mux_scan_decoder.sv - directed self-checking bench for time_mux_scan_decoder
module tb_time_mux_scan_decoder;
  import sevenseg_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  an;
  logic [6:0]  sseg;
  logic [15:0] value;
  logic [3:0]  digit_valid;
  logic        frame_valid;
  logic        seg_err;
  logic        an_err;
  logic        stale;

  int n_checks = 0;
  int n_errors = 0;
  int frames   = 0;
  logic [15:0] sw = 16'hBEEF;

  time_mux_scan_decoder #(
    .SETTLE_CYCLES (4),
    .STALE_CYCLES  (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .an          (an),
    .sseg        (sseg),
    .value       (value),
    .digit_valid (digit_valid),
    .frame_valid (frame_valid),
    .seg_err     (seg_err),
    .an_err      (an_err),
    .stale       (stale)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s);
    an   = a;
    sseg = s;
  endtask

  initial begin
    reset = 1'b1;
    drive(4'hF, 7'h7F);
    step(3);
    check("rst_value", 32'(value), 32'h0);
    check("rst_dv", 32'(digit_valid), 32'h0);
    check("rst_frame", 32'(frame_valid), 32'h0);
    check("rst_seg_err", 32'(seg_err), 32'h0);
    check("rst_an_err", 32'(an_err), 32'h0);
    check("rst_stale", 32'(stale), 32'h0);
    reset = 1'b0;
    step(6);

    // 3-cycle glitch must not capture
    drive(4'b1110, 7'h79);
    step(3);
    drive(4'hF, 7'h7F);
    step(6);
    check("glitch_value", 32'(value), 32'h0);
    check("glitch_dv", 32'(digit_valid), 32'h0);

    drive(4'b1110, 7'h79);
    step(4);
    check("hold_pre_value", 32'(value), 32'h0);
    check("stale_after_idle", 32'(stale), 32'h1);
    step(1);
    check("hold_value", 32'(value), 32'h0001);
    check("hold_dv", 32'(digit_valid), 32'h1);
    check("hold_stale_clr", 32'(stale), 32'h0);
    check("hold_frame", 32'(frame_valid), 32'h0);

    // undecodable pattern on slot 2
    drive(4'b1011, 7'h7F);
    step(5);
    check("bad_seg_pulse", 32'(seg_err), 32'h1);
    check("bad_seg_dv", 32'(digit_valid), 32'h1);
    check("bad_seg_value", 32'(value), 32'h0001);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("bad_seg_norepeat", 32'(seg_err), 32'h0);
    end

    drive(4'b1101, 7'h24);
    step(5);
    check("slot1_value", 32'(value), 32'h0021);
    check("slot1_dv", 32'(digit_valid), 32'h3);

    drive(4'b0011, 7'h79);
    step(5);
    check("multi_pulse", 32'(an_err), 32'h1);
    check("multi_value", 32'(value), 32'h0021);
    check("multi_dv", 32'(digit_valid), 32'h3);
    step(1);
    check("multi_norepeat", 32'(an_err), 32'h0);

    drive(4'b1011, 7'h06);
    step(5);
    check("slot2_value", 32'(value), 32'h0E21);
    check("slot2_dv", 32'(digit_valid), 32'h7);
    check("slot2_noframe", 32'(frame_valid), 32'h0);

    drive(4'b0111, 7'h03);
    step(5);
    check("slot3_value", 32'(value), 32'hBE21);
    check("slot3_dv", 32'(digit_valid), 32'hF);
    check("slot3_frame", 32'(frame_valid), 32'h1);

    // stale after 16 idle cycles
    drive(4'hF, 7'h7F);
    step(1);
    check("frame_width", 32'(frame_valid), 32'h0);
    step(14);
    check("stale_pre", 32'(stale), 32'h0);
    step(1);
    check("stale_set", 32'(stale), 32'h1);
    check("stale_dv", 32'(digit_valid), 32'h0);
    check("stale_value", 32'(value), 32'hBE21);

    drive(4'b0111, 7'h0E);
    step(5);
    check("unstale_flag", 32'(stale), 32'h0);
    check("unstale_value", 32'(value), 32'hFE21);
    check("unstale_dv", 32'(digit_valid), 32'h8);
    check("unstale_noframe", 32'(frame_valid), 32'h0);

    // loopback scan of 16'hBEEF; seen starts at 4'b1000 so frames complete on slot 2 each scan
    for (int scan = 0; scan < 2; scan++) begin
      for (int d = 0; d < 4; d++) begin
        drive(~(4'b0001 << d), hex_to_sseg(sw[d*4 +: 4]));
        for (int c = 0; c < 6; c++) begin
          step(1);
          if (frame_valid) frames++;
        end
      end
    end
    check("loop_value", 32'(value), 32'hBEEF);
    check("loop_dv", 32'(digit_valid), 32'hF);
    check("loop_frames", 32'(frames), 32'd2);
    check("loop_stale", 32'(stale), 32'h0);

    // reset mid-dwell
    drive(4'b1110, 7'h12);
    step(2);
    reset = 1'b1;
    step(1);
    check("midrst_value", 32'(value), 32'h0);
    check("midrst_dv", 32'(digit_valid), 32'h0);
    check("midrst_stale", 32'(stale), 32'h0);
    reset = 1'b0;
    step(4);
    check("midrst_early_dv", 32'(digit_valid), 32'h0);
    step(1);
    check("midrst_value_cap", 32'(value), 32'h0005);
    check("midrst_dv_cap", 32'(digit_valid), 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/time_mux_scan_decoder.md
# time_mux_scan_decoder

Receive-side counterpart of the time-multiplexed seven-segment display driver: samples the active-low anode strobes and segment lines, waits for each digit slot to settle, decodes the segment pattern back to a hex nibble, and reassembles the 16-bit displayed value. Used for loopback self-test (driver outputs wired back in) and for capturing an external board's scanned display.

## Interface
- SETTLE_CYCLES, 4 — consecutive identical samples required before a slot is captured; legal range 2..255.
- STALE_CYCLES, 1000000 — cycles without a successful capture before data is declared stale; legal range ≥ 16.
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- an  input  4  anode strobes, active-low; an[k]=0 selects slot k (slot 0 = value[3:0]).
- sseg  input  7  segment lines, active-low, sseg[6:0] = {g,f,e,d,c,b,a}.
- value  output  16  reconstructed value, nibble k = slot k.
- digit_valid  output  4  bit k set when nibble k holds a successfully decoded digit.
- frame_valid  output  1  one-cycle pulse when all four slots have been captured since the previous pulse.
- seg_err  output  1  one-cycle pulse: settled slot carried an undecodable pattern.
- an_err  output  1  one-cycle pulse: settled anode word had more than one low bit.
- stale  output  1  level: no successful capture for STALE_CYCLES cycles.

## Operation
- Input stage: {an, sseg} registered once into a sample register; all logic works on the sample.
- Stability counter: resets to 1 when the new sample differs from the previous one, otherwise increments and saturates at SETTLE_CYCLES. A `captured` flag clears on any change.
- Capture fires once per dwell, in the cycle the counter reaches SETTLE_CYCLES with `captured` clear; `captured` is then set.
- At capture:
  - an = 4'hF (blank): ignored, no flags.
  - exactly one low bit k: decode sseg. Hex digit patterns (active-low {g..a}): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E. On match, write nibble k, set digit_valid[k] and seen[k], and restart the stale counter. On no match, pulse seg_err, clear digit_valid[k] and seen[k], and leave nibble k unchanged.
  - two or more low bits: pulse an_err; no other state changes.
- Frame: when a successful capture makes seen = 4'hF, pulse frame_valid in the same cycle value is updated, and clear seen to 0. Slot order is irrelevant; repeated captures of the same slot only overwrite the nibble.
- Stale: counter increments every cycle and resets on each successful capture. On reaching STALE_CYCLES, stale is set and digit_valid and seen are cleared; value is retained. stale clears on the next successful capture.
- Same-cycle events: a capture completing a frame together with stale expiry gives the capture priority; the stale counter resets and stale stays 0.

## Timing
- Reset values: value=0, digit_valid=0, frame_valid=0, seg_err=0, an_err=0, stale=0. Internal state after reset: seen=0, counters=0, `captured`=0.
- Reset asserted mid-dwell discards the dwell. The slot is recaptured SETTLE_CYCLES edges after reset deasserts, counted from the first sampling edge.
- Latency: with new {an, sseg} sampled at edge 0 and held, value, digit_valid and pulses update at edge SETTLE_CYCLES (edge 4 by default).
- Glitches held for fewer than SETTLE_CYCLES sampling edges produce no capture.
- All outputs are registered, and pulses are exactly one cycle wide.

## Structure
- Shared package `sevenseg_pkg`:
  - the 16 active-low segment pattern constants;
  - NUM_DIGITS = 4;
  - the blank anode constant 4'hF.
- The display driver's hex-to-segment encoder uses the same package, so both directions share one table.
- Sub-module `sevenseg_to_hex` is purely combinational: sseg[6:0] in, nibble[3:0] and hit out. It is instantiated once, after the sample register.
- Top level holds the sample register, stability counter, `captured` flag, seen mask, stale counter and output registers.

## Test plan
- Loopback: driver fed sw=16'hBEEF with a slow scan. Required: value=16'hBEEF, digit_valid=4'hF, and frame_valid pulses once per full scan.
- Glitch: 3-cycle an=4'b1110 with sseg=7'h79, then blank. Required: no capture and value unchanged. Holding 4 cycles then gives value[3:0]=1 at edge 4.
- Bad pattern: an=4'b1011 with sseg=7'h7F held. Required: one seg_err pulse, digit_valid[2]=0, nibble 2 unchanged, and no repeat pulse while held.
- Multi-anode: an=4'b0011 held. Required: one an_err pulse; value, digit_valid and seen are unchanged.
- Stale (STALE_CYCLES=16 override): a valid frame, then blank held for 16 cycles. Required: stale=1 and digit_valid=0 with value retained. The next good capture clears stale.
- Reset mid-dwell: reset on cycle 2 of a dwell. Required: all outputs zero, and the slot recaptured 4 edges after release.
